// File: rtl/vgg_pkg.sv
// Shared types and constants for the vgg16_lite frame sequencer.
// Holds the sequencer FSM encoding, the pixel-count helper and the default word sizes.
package vgg_pkg;

  localparam int DWIDTH_DEF         = 32;
  localparam int NUM_CHANNEL_IN_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

  // Pixel beats per frame.
  function automatic int frame_total(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/result_queue.sv
// Small synchronous FIFO that buffers core results ahead of the output FIFO.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module result_queue #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the occupancy count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vgg_frame_ctrl.sv
// Frame sequencer: streams WIDTH*HEIGHT pixel beats into the core, then buffers
// its results towards the output FIFO before accepting the next frame.
module vgg_frame_ctrl
  import vgg_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int NUM_CHANNEL_IN = NUM_CHANNEL_IN_DEF,
  parameter int WIDTH          = 56,
  parameter int HEIGHT         = 56,
  parameter int OUT_DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_CHANNEL_IN*DWIDTH-1:0] in_rdata,
  input  logic                             in_empty,
  output logic                             in_rdreq,
  output logic [NUM_CHANNEL_IN*DWIDTH-1:0] core_data_in,
  output logic                             core_valid_in,
  input  logic [DWIDTH-1:0]                core_data_out,
  input  logic                             core_class,
  input  logic                             core_valid_out,
  input  logic                             core_done,
  output logic [DWIDTH:0]                  out_wdata,
  output logic                             out_wrreq,
  input  logic                             out_full,
  output logic                             busy,
  output logic [15:0]                      frame_cnt,
  output logic                             err
);

  localparam int TOTAL = frame_total(WIDTH, HEIGHT);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int QC_W  = $clog2(OUT_DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  issued;
  logic [DWIDTH:0]   q_head;
  logic              q_empty;
  logic              q_full;
  logic [QC_W-1:0]   q_count;
  logic              drop;
  logic              last_read;
  logic              frame_end;

  assign in_rdreq     = (state == ST_STREAM) && !in_empty && (issued < CNT_W'(TOTAL));
  assign last_read    = in_rdreq && (issued == CNT_W'(TOTAL - 1));
  assign core_data_in = in_rdata;
  assign out_wrreq    = !q_empty && !out_full;
  assign out_wdata    = q_empty ? '0 : q_head;
  assign busy         = (state != ST_IDLE);
  assign drop         = core_valid_out && q_full && !out_wrreq;
  // A result arriving in the same cycle still belongs to this frame.
  assign frame_end    = (state == ST_FLUSH) && (q_count == '0) && !core_valid_out;

  result_queue #(
    .W     (DWIDTH + 1),
    .DEPTH (OUT_DEPTH)
  ) u_queue (
    .clk    (clk),
    .resetn (resetn),
    .push   (core_valid_out),
    .pop    (out_wrreq),
    .wdata  ({core_class, core_data_out}),
    .rdata  (q_head),
    .empty  (q_empty),
    .full   (q_full),
    .count  (q_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!in_empty) state_nxt = ST_STREAM;
      ST_STREAM: if (last_read) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (core_done) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (frame_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      issued        <= '0;
      core_valid_in <= 1'b0;
      frame_cnt     <= '0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      core_valid_in <= in_rdreq;
      if (state == ST_IDLE)  issued <= '0;
      else if (in_rdreq)     issued <= issued + CNT_W'(1);
      if (frame_end)         frame_cnt <= frame_cnt + 16'd1;
      if (drop || (core_done && state != ST_DRAIN)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vgg_frame_ctrl.sv
// Directed bench for vgg_frame_ctrl on a 4x2 frame with a behavioural input FIFO,
// core and output FIFO; results are tracked against a bench-side queue model.
module tb_vgg_frame_ctrl;

  localparam int DW    = 32;
  localparam int NCH   = 8;
  localparam int TOTAL = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH*DW-1:0] in_rdata;
  logic              in_empty;
  logic              in_rdreq;
  logic [NCH*DW-1:0] core_data_in;
  logic              core_valid_in;
  logic [DW-1:0]     core_data_out;
  logic              core_class;
  logic              core_valid_out;
  logic              core_done;
  logic [DW:0]       out_wdata;
  logic              out_wrreq;
  logic              out_full;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              err;

  int          checks = 0;
  int          errors = 0;
  int          pix_rd = 0;
  int          pix_chk = 0;
  int          res_tag = 0;
  logic [15:0] exp_fc = '0;
  logic        exp_err = 1'b0;
  logic [DW:0] exp_q[$];

  vgg_frame_ctrl #(
    .DWIDTH         (DW),
    .NUM_CHANNEL_IN (NCH),
    .WIDTH          (4),
    .HEIGHT         (2),
    .OUT_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_rdata       (in_rdata),
    .in_empty       (in_empty),
    .in_rdreq       (in_rdreq),
    .core_data_in   (core_data_in),
    .core_valid_in  (core_valid_in),
    .core_data_out  (core_data_out),
    .core_class     (core_class),
    .core_valid_out (core_valid_out),
    .core_done      (core_done),
    .out_wdata      (out_wdata),
    .out_wrreq      (out_wrreq),
    .out_full       (out_full),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pix_word(input int p);
    logic [NCH*DW-1:0] w;
    for (int i = 0; i < NCH; i++) w[i*DW +: DW] = 32'hA000_0000 + 32'(p * 16 + i);
    return w;
  endfunction

  task automatic check_reset_outputs();
    check("rst_in_rdreq",      256'(in_rdreq),      256'(0));
    check("rst_core_valid_in", 256'(core_valid_in), 256'(0));
    check("rst_out_wrreq",     256'(out_wrreq),     256'(0));
    check("rst_out_wdata",     256'(out_wdata),     256'(0));
    check("rst_busy",          256'(busy),          256'(0));
    check("rst_frame_cnt",     256'(frame_cnt),     256'(0));
    check("rst_err",           256'(err),           256'(0));
  endtask

  // One frame: alt = input FIFO empty on odd cycles, n_res results after the
  // last pixel, out_full high for full_cyc cycles from the first result slot,
  // early = core_done pulse during STREAM, abort_at > 0 = reset after that many reads.
  task automatic run_frame(input bit alt, input int n_res, input int full_cyc,
                           input bit early, input int abort_at);
    int   reads = 0;
    int   valids = 0;
    int   res_sent = 0;
    int   full_left = full_cyc;
    bit   prev_rd = 1'b0;
    bit   done_sent = 1'b0;
    bit   early_sent = 1'b0;
    bit   finished = 1'b0;
    bit   exp_pop;
    logic [DW:0] head;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(posedge clk);
      #1;
      in_empty = (reads >= TOTAL) || (alt && cyc[0]);
      if (prev_rd) begin
        in_rdata = pix_word(pix_rd);
        pix_rd++;
      end
      core_valid_out = 1'b0;
      core_done      = 1'b0;
      if (valids == TOTAL && res_sent < n_res) begin
        core_valid_out = 1'b1;
        core_class     = res_tag[0];
        core_data_out  = 32'h5000_0000 + 32'(res_tag);
        res_tag++;
        res_sent++;
      end else if (valids == TOTAL && !done_sent) begin
        core_done = 1'b1;
        done_sent = 1'b1;
      end
      if (early && reads == 3 && !early_sent) begin
        core_done  = 1'b1;
        early_sent = 1'b1;
        exp_err    = 1'b1;
      end
      out_full = (valids == TOTAL) && (full_left > 0);
      if (out_full) full_left--;

      @(negedge clk);
      exp_pop = (exp_q.size() > 0) && !out_full;
      check("out_wrreq", 256'(out_wrreq), 256'(exp_pop));
      if (exp_pop && out_wrreq) begin
        head = exp_q.pop_front();
        check("out_wdata", 256'(out_wdata), 256'(head));
      end
      if (core_valid_out) begin
        if (exp_q.size() == DEPTH) exp_err = 1'b1;
        else exp_q.push_back({core_class, core_data_out});
      end
      if (cyc == 1 && !alt) check("first_rd_latency", 256'(in_rdreq), 256'(1));
      if (in_rdreq) begin
        check("rdreq_while_empty", 256'(in_empty), 256'(0));
        reads++;
      end
      check("valid_in_latency", 256'(core_valid_in), 256'(prev_rd));
      if (core_valid_in) begin
        check("pixel_order", core_data_in, pix_word(pix_chk));
        pix_chk++;
        valids++;
      end
      if (done_sent && exp_q.size() > 0) check("busy_in_flush", 256'(busy), 256'(1));
      prev_rd = in_rdreq;
      if (abort_at > 0 && reads == abort_at) begin
        #2 resetn = 1'b0;
        #1 check_reset_outputs();
        in_empty       = 1'b1;
        core_valid_out = 1'b0;
        core_done      = 1'b0;
        out_full       = 1'b0;
        exp_q.delete();
        exp_fc  = '0;
        exp_err = 1'b0;
        pix_chk = pix_rd;
        @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (done_sent && !busy && exp_q.size() == 0) finished = 1'b1;
    end
    check("frame_finished", 256'(finished), 256'(1));
    if (finished) exp_fc++;
    check("read_count",  256'(reads),     256'(TOTAL));
    check("valid_count", 256'(valids),    256'(TOTAL));
    check("frame_cnt",   256'(frame_cnt), 256'(exp_fc));
    check("err",         256'(err),       256'(exp_err));
    check("idle_busy",   256'(busy),      256'(0));
  endtask

  initial begin
    resetn         = 1'b0;
    in_rdata       = '0;
    in_empty       = 1'b1;
    core_data_out  = '0;
    core_class     = 1'b0;
    core_valid_out = 1'b0;
    core_done      = 1'b0;
    out_full       = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    resetn = 1'b1;

    run_frame(1'b0, 3, 0,  1'b0, 0);  // basic frame
    run_frame(1'b1, 3, 0,  1'b0, 0);  // input FIFO empty every other cycle
    run_frame(1'b0, 4, 10, 1'b0, 0);  // output backpressure, queue fills exactly
    run_frame(1'b0, 5, 10, 1'b0, 0);  // overflow drops the fifth result
    run_frame(1'b0, 2, 0,  1'b0, 3);  // reset after three reads
    run_frame(1'b0, 2, 0,  1'b0, 0);  // full frame after the abort
    run_frame(1'b0, 3, 0,  1'b1, 0);  // stray core_done during STREAM

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
